n64_bus_router: RTL and testbench
=================================

# n64_bus_router

Routes single-beat transactions from the N64 PI bus master to one of several device slaves (SDRAM, bootloader, DD, flashram, config) selected by the transaction ID, and returns the device's acknowledge and read data to the master. Sits directly downstream of the PI bus controller and upstream of the per-device controllers. Guarantees that every accepted request completes exactly once, including requests to unimplemented IDs and, optionally, requests a device never answers.

## Interface
Parameters:
- NUM_DEV, 8, number of device ports; valid IDs are 0..NUM_DEV-1
- TIMEOUT_CYCLES, 1023, wait cycles before a forced completion (used only with N64_BUS_TIMEOUT_EN)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- up_request  in  1  master request; held high until up_ack
- up_write  in  1  1 = write, 0 = read; stable while up_request
- up_id  in  sc64::e_n64_id  target device ID; stable while up_request
- up_address  in  32  byte address; stable while up_request
- up_wdata  in  16  write data; stable while up_request
- up_ack  out  1  one-cycle completion pulse
- up_rdata  out  16  read data; valid in the up_ack cycle
- dev_request  out  NUM_DEV  one-hot request to the selected device
- dev_write  out  1  latched up_write
- dev_address  out  32  latched up_address
- dev_wdata  out  16  latched up_wdata
- dev_ack  in  NUM_DEV  per-device one-cycle acknowledge
- dev_rdata  in  NUM_DEV×16  per-device read data; valid with dev_ack
- err_clear  in  1  clears err_count and timeout_flag
- err_count  out  8  saturating count of invalid-ID and timed-out transactions
- timeout_flag  out  1  sticky; set when any transaction times out

## Operation
- Reset values: all outputs 0; the state machine is in IDLE; the wait counter is 0.
- IDLE: when up_request is high and up_ack is low, latch id, write, address, and wdata.
  - Valid ID: go to WAIT and set dev_request[id].
  - ID >= NUM_DEV: go to DONE, set up_rdata = 16'hFFFF, drop any write, and increment err_count.
- WAIT: dev_request[id] stays high.
  - On dev_ack[id]: clear dev_request, capture dev_rdata[id] into up_rdata (capture 0 for writes), and go to DONE.
  - dev_ack on any non-selected device is ignored.
- DONE: pulse up_ack for one cycle, then return to IDLE.
- err_count saturates at 8'hFF.
- err_clear has priority over a same-cycle increment: the result is 0.
- dev_write, dev_address, and dev_wdata hold their last latched values outside WAIT.

## Timing
- Request accepted in cycle 0; dev_request high from cycle 1.
- Device acks in cycle k; dev_request is low in cycle k+1 and up_ack is high in cycle k+1.
- Minimum round trip is therefore 3 cycles: device ack at cycle 1 gives up_ack at cycle 2.
- Invalid-ID completion: up_ack in cycle 1.
- The master drops up_request in the cycle after up_ack. The router must not re-accept during the up_ack cycle, which is guaranteed by the DONE→IDLE step.
- Back-to-back accepts are possible every 3 cycles with a zero-wait device.
- reset_n asserted mid-transaction: dev_request and up_ack drop immediately and no completion is issued. The master is reset by the same hard reset.

## Configuration
- N64_BUS_TIMEOUT_EN defined:
  - The wait counter counts cycles spent in WAIT.
  - When the counter reaches TIMEOUT_CYCLES without dev_ack[id], clear dev_request, set up_rdata = 16'hFFFF, set timeout_flag, increment err_count, and go to DONE.
  - If dev_ack[id] arrives in the expiry cycle, the device ack wins: real data is returned and no error is recorded.
- N64_BUS_TIMEOUT_EN undefined:
  - No counter is built; WAIT lasts indefinitely.
  - timeout_flag is tied to 0.

## Test plan
- Read, ID 0, device acks 2 cycles after dev_request with dev_rdata[0] = 16'hA55A → up_ack exactly 3 cycles after acceptance with up_rdata = 16'hA55A; dev_request[0] high for exactly 2 cycles.
- Write, ID 3, address 32'h1000_0002, wdata 16'h1234 → dev_address = 32'h1000_0002, dev_wdata = 16'h1234, dev_write = 1, only dev_request[3] high; one up_ack.
- ID 9 with NUM_DEV = 8 → up_ack at cycle 1, up_rdata = 16'hFFFF, err_count = 1, no dev_request bit ever set.
- With N64_BUS_TIMEOUT_EN, TIMEOUT_CYCLES = 16, silent device → up_ack with 16'hFFFF after the 16-cycle timeout plus 2 cycles, timeout_flag = 1; err_clear then returns err_count = 0 and timeout_flag = 0.
- Spurious dev_ack[2] while waiting on ID 1, then dev_ack[1] → single up_ack carrying dev_rdata[1].
- reset_n pulsed low during WAIT → all outputs 0 asynchronously; no up_ack after release; the next request completes normally.

Source files
------------

// File: rtl/n64_bus_router.sv
// n64_bus_router: routes single-beat PI bus transactions to per-device slaves by ID; define N64_BUS_TIMEOUT_EN to force completion of unanswered requests.
module n64_bus_router #(
  parameter int NUM_DEV = 8,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int ID_W = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    up_request,
  input  logic                    up_write,
  input  logic [ID_W-1:0]         up_id,
  input  logic [31:0]             up_address,
  input  logic [15:0]             up_wdata,
  output logic                    up_ack,
  output logic [15:0]             up_rdata,
  output logic [NUM_DEV-1:0]      dev_request,
  output logic                    dev_write,
  output logic [31:0]             dev_address,
  output logic [15:0]             dev_wdata,
  input  logic [NUM_DEV-1:0]      dev_ack,
  input  logic [NUM_DEV*16-1:0]   dev_rdata,
  input  logic                    err_clear,
  output logic [7:0]              err_count,
  output logic                    timeout_flag
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [ID_W-1:0] id_q, id_d;
  logic write_q, write_d;
  logic [31:0] address_q, address_d;
  logic [15:0] wdata_q, wdata_d, rdata_q, rdata_d, rdata_sel;
  logic [7:0] err_q, err_d;
  logic [NUM_DEV-1:0] req_oh;
  logic ack_sel, err_inc, timeout;
  always_comb begin
    ack_sel = 1'b0;
    rdata_sel = '0;
    req_oh = '0;
    for (int i = 0; i < NUM_DEV; i++)
      if (int'(id_q) == i) begin
        ack_sel = dev_ack[i];
        rdata_sel = dev_rdata[16*i +: 16];
        req_oh[i] = 1'b1;
      end
  end
`ifdef N64_BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic tflag_q, tflag_d;
  // a same-cycle device ack beats expiry
  assign timeout = (state_q == WAIT) && !ack_sel && (cnt_q == CW'(TIMEOUT_CYCLES));
  assign cnt_d = (state_q == WAIT) ? cnt_q + 1'b1 : '0;
  assign tflag_d = err_clear ? 1'b0 : (tflag_q | timeout);
  assign timeout_flag = tflag_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt_q <= '0;
      tflag_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tflag_q <= tflag_d;
    end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
  assign timeout_flag = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    id_d = id_q;
    write_d = write_q;
    address_d = address_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_inc = 1'b0;
    case (state_q)
      IDLE:
        if (up_request && !up_ack) begin
          id_d = up_id;
          address_d = up_address;
          wdata_d = up_wdata;
          if (int'(up_id) < NUM_DEV) begin
            write_d = up_write;
            state_d = WAIT;
          end else begin
            write_d = 1'b0;
            rdata_d = 16'hFFFF;
            err_inc = 1'b1;
            state_d = DONE;
          end
        end
      WAIT:
        if (ack_sel) begin
          rdata_d = write_q ? 16'h0000 : rdata_sel;
          state_d = DONE;
        end else if (timeout) begin
          rdata_d = 16'hFFFF;
          err_inc = 1'b1;
          state_d = DONE;
        end
      default: state_d = IDLE;
    endcase
    err_d = err_clear ? 8'h00 : (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      id_q <= '0;
      write_q <= 1'b0;
      address_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q <= '0;
    end else begin
      state_q <= state_d;
      id_q <= id_d;
      write_q <= write_d;
      address_q <= address_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  assign up_ack = (state_q == DONE);
  assign up_rdata = rdata_q;
  assign dev_request = (state_q == WAIT) ? req_oh : '0;
  assign dev_write = write_q;
  assign dev_address = address_q;
  assign dev_wdata = wdata_q;
  assign err_count = err_q;
endmodule

// File: tb/tb_n64_bus_router.sv
// tb_n64_bus_router: vector table of single transactions plus hand sequences for reset, error counter and timeout.
module tb_n64_bus_router;
  localparam int NUM_DEV = 8;
  logic clk = 1'b0;
  logic reset_n;
  logic up_request, up_write, up_ack, dev_write, err_clear, timeout_flag;
  logic [3:0] up_id;
  logic [31:0] up_address, dev_address;
  logic [15:0] up_wdata, up_rdata, dev_wdata;
  logic [NUM_DEV-1:0] dev_request, dev_ack;
  logic [NUM_DEV*16-1:0] dev_rdata;
  logic [7:0] err_count;
  int total = 0;
  int bad = 0;

  n64_bus_router #(.NUM_DEV(NUM_DEV), .TIMEOUT_CYCLES(16), .ID_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .up_request(up_request), .up_write(up_write),
    .up_id(up_id), .up_address(up_address), .up_wdata(up_wdata), .up_ack(up_ack),
    .up_rdata(up_rdata), .dev_request(dev_request), .dev_write(dev_write),
    .dev_address(dev_address), .dev_wdata(dev_wdata), .dev_ack(dev_ack),
    .dev_rdata(dev_rdata), .err_clear(err_clear), .err_count(err_count),
    .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one request from IDLE and plays a device that acks in its lat-th request cycle (lat=0: never).
  task automatic run_txn(input logic w, input logic [3:0] id, input logic [31:0] a, input logic [15:0] wd,
                         input int lat, input logic [15:0] rdv, input int spur,
                         output int ack_cyc, output int req_cyc, output int acks, output logic [15:0] rd,
                         output logic other, output logic dw, output logic [31:0] da, output logic [15:0] dwd);
    int idx;
    logic mine;
    idx = int'(id);
    ack_cyc = -1; req_cyc = 0; acks = 0; rd = '0; other = 1'b0; dw = 1'b0; da = '0; dwd = '0;
    for (int s = 0; s < NUM_DEV; s++) dev_rdata[s*16 +: 16] = 16'hC000 | 16'(s);
    for (int s = 0; s < NUM_DEV; s++) if (s == idx) dev_rdata[s*16 +: 16] = rdv;
    dev_ack = '0;
    up_request = 1'b1; up_write = w; up_id = id; up_address = a; up_wdata = wd;
    for (int c = 1; c <= 45; c++) begin
      tick();
      dev_ack = '0;
      if (ack_cyc >= 0) up_request = 1'b0;
      if (up_ack) begin
        acks++;
        if (ack_cyc < 0) begin
          ack_cyc = c; rd = up_rdata; dw = dev_write; da = dev_address; dwd = dev_wdata;
        end
      end
      mine = 1'b0;
      for (int s = 0; s < NUM_DEV; s++)
        if (dev_request[s]) begin
          if (s == idx) mine = 1'b1;
          else other = 1'b1;
        end
      if (mine) begin
        req_cyc++;
        for (int s = 0; s < NUM_DEV; s++) begin
          if (s == idx && req_cyc == lat) dev_ack[s] = 1'b1;
          if (s == spur && req_cyc == 1 && req_cyc != lat) dev_ack[s] = 1'b1;
        end
      end
      if (ack_cyc >= 0 && c >= ack_cyc + 3) break;
    end
    dev_ack = '0;
    up_request = 1'b0;
  endtask

  typedef struct {
    logic w; logic [3:0] id; logic [31:0] a; logic [15:0] wd;
    int lat; logic [15:0] rdv; int spur;
    int e_ack; int e_req; logic [15:0] e_rd; logic e_dw; logic [7:0] e_err;
  } vec_t;
  vec_t vt[7];

  initial begin
    int ack_cyc, req_cyc, acks, quiet;
    logic [15:0] rd, dwd;
    logic other, dw;
    logic [31:0] da;
    vt[0] = '{1'b0, 4'd0, 32'h0000_0100, 16'h0000, 2, 16'hA55A, -1, 3, 2, 16'hA55A, 1'b0, 8'd0};
    vt[1] = '{1'b1, 4'd3, 32'h1000_0002, 16'h1234, 1, 16'hBEEF, -1, 2, 1, 16'h0000, 1'b1, 8'd0};
    vt[2] = '{1'b0, 4'd9, 32'h2000_0000, 16'h0000, 1, 16'h0000, -1, 1, 0, 16'hFFFF, 1'b0, 8'd1};
    vt[3] = '{1'b0, 4'd1, 32'h0300_0040, 16'h0000, 3, 16'h1111, 2, 4, 3, 16'h1111, 1'b0, 8'd1};
    vt[4] = '{1'b0, 4'd7, 32'h0000_7FFE, 16'h0000, 1, 16'h7E7E, -1, 2, 1, 16'h7E7E, 1'b0, 8'd1};
    vt[5] = '{1'b1, 4'd15, 32'hFFFF_FFFE, 16'h5AA5, 1, 16'h0000, -1, 1, 0, 16'hFFFF, 1'b0, 8'd2};
    vt[6] = '{1'b0, 4'd8, 32'h0000_0008, 16'h0000, 1, 16'h0000, -1, 1, 0, 16'hFFFF, 1'b0, 8'd3};

    reset_n = 1'b0; up_request = 1'b0; up_write = 1'b0; up_id = '0; up_address = '0;
    up_wdata = '0; dev_ack = '0; dev_rdata = '0; err_clear = 1'b0;
    #12;
    chk("rst_up_ack", {31'b0, up_ack}, 32'd0);
    chk("rst_up_rdata", {16'b0, up_rdata}, 32'd0);
    chk("rst_dev_request", {24'b0, dev_request}, 32'd0);
    chk("rst_dev_addr", dev_address, 32'd0);
    chk("rst_err_count", {24'b0, err_count}, 32'd0);
    chk("rst_timeout_flag", {31'b0, timeout_flag}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_txn(vt[i].w, vt[i].id, vt[i].a, vt[i].wd, vt[i].lat, vt[i].rdv, vt[i].spur,
              ack_cyc, req_cyc, acks, rd, other, dw, da, dwd);
      chk($sformatf("v%0d_ack_cycle", i), ack_cyc, vt[i].e_ack);
      chk($sformatf("v%0d_ack_count", i), acks, 1);
      chk($sformatf("v%0d_req_cycles", i), req_cyc, vt[i].e_req);
      chk($sformatf("v%0d_rdata", i), {16'b0, rd}, {16'b0, vt[i].e_rd});
      chk($sformatf("v%0d_other_req", i), {31'b0, other}, 32'd0);
      chk($sformatf("v%0d_dev_write", i), {31'b0, dw}, {31'b0, vt[i].e_dw});
      chk($sformatf("v%0d_dev_addr", i), da, vt[i].a);
      chk($sformatf("v%0d_dev_wdata", i), {16'b0, dwd}, {16'b0, vt[i].wd});
      chk($sformatf("v%0d_err_count", i), {24'b0, err_count}, {24'b0, vt[i].e_err});
    end

    // asynchronous reset while waiting on a silent device
    dev_ack = '0;
    up_request = 1'b1; up_write = 1'b0; up_id = 4'd2; up_address = 32'h0000_0222;
    tick(); tick(); tick();
    chk("mid_rst_pre_req", {24'b0, dev_request}, 32'h04);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_dev_request", {24'b0, dev_request}, 32'd0);
    chk("mid_rst_up_ack", {31'b0, up_ack}, 32'd0);
    chk("mid_rst_up_rdata", {16'b0, up_rdata}, 32'd0);
    chk("mid_rst_err_count", {24'b0, err_count}, 32'd0);
    chk("mid_rst_dev_addr", dev_address, 32'd0);
    up_request = 1'b0;
    tick();
    reset_n = 1'b1;
    quiet = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (up_ack || dev_request != '0) quiet++;
    end
    chk("post_rst_quiet", quiet, 0);
    run_txn(1'b0, 4'd4, 32'h0000_0444, 16'h0000, 1, 16'h4444, -1, ack_cyc, req_cyc, acks, rd, other, dw, da, dwd);
    chk("post_rst_ack_cycle", ack_cyc, 2);
    chk("post_rst_rdata", {16'b0, rd}, 32'h4444);

`ifdef N64_BUS_TIMEOUT_EN
    run_txn(1'b0, 4'd5, 32'h0000_0555, 16'h0000, 0, 16'h5555, -1, ack_cyc, req_cyc, acks, rd, other, dw, da, dwd);
    chk("to_ack_cycle", ack_cyc, 18);
    chk("to_req_cycles", req_cyc, 17);
    chk("to_ack_count", acks, 1);
    chk("to_rdata", {16'b0, rd}, 32'hFFFF);
    chk("to_flag", {31'b0, timeout_flag}, 32'd1);
    chk("to_err_count", {24'b0, err_count}, 32'd1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("to_clear_err", {24'b0, err_count}, 32'd0);
    chk("to_clear_flag", {31'b0, timeout_flag}, 32'd0);
    run_txn(1'b0, 4'd6, 32'h0000_0666, 16'h0000, 17, 16'h6666, -1, ack_cyc, req_cyc, acks, rd, other, dw, da, dwd);
    chk("edge_ack_cycle", ack_cyc, 18);
    chk("edge_rdata", {16'b0, rd}, 32'h6666);
    chk("edge_err_count", {24'b0, err_count}, 32'd0);
    chk("edge_flag", {31'b0, timeout_flag}, 32'd0);
`endif

    // clear beats a same-cycle increment
    run_txn(1'b0, 4'd11, 32'h0, 16'h0, 1, 16'h0, -1, ack_cyc, req_cyc, acks, rd, other, dw, da, dwd);
    chk("pre_clear_err", {24'b0, err_count}, 32'd1);
    up_request = 1'b1; up_id = 4'd10; err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("clear_prio_ack", {31'b0, up_ack}, 32'd1);
    chk("clear_prio_err", {24'b0, err_count}, 32'd0);
    tick();
    up_request = 1'b0;
    tick();

    for (int n = 0; n < 255; n++) begin
      up_request = 1'b1; up_id = 4'd12;
      tick(); tick();
      up_request = 1'b0;
      tick();
    end
    chk("sat_255", {24'b0, err_count}, 32'hFF);
    for (int n = 0; n < 5; n++) begin
      up_request = 1'b1; up_id = 4'd13;
      tick(); tick();
      up_request = 1'b0;
      tick();
    end
    chk("sat_hold", {24'b0, err_count}, 32'hFF);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("sat_clear", {24'b0, err_count}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
